rggen_demux: RTL and testbench
==============================

# rggen_demux

Distribution counterpart of the one-hot register read-data mux: accepts one request stream carrying a one-hot target select and a data word, and forwards it to exactly one of ENTRIES downstream targets using per-target valid/ready handshakes. The block sits between the bus-side request path and the per-register/per-block write ports. It registers the forwarded request with a two-deep skid buffer, giving full throughput with no combinational ready path from downstream to upstream. It also discards and counts requests whose select is not one-hot.

## Interface
- WIDTH, 32, data word width, minimum 1
- ENTRIES, 2, number of downstream targets, minimum 1
- COUNT_WIDTH, 8, width of the saturating error counter
- i_clk  input  1  clock
- i_rst_n  input  1  reset; the clock is a single domain and reset is asynchronous, active-low
- i_valid  input  1  upstream request valid
- o_ready  output  1  upstream ready; registered, no combinational dependence on i_ready
- i_select  input  ENTRIES  one-hot target select
- i_data  input  WIDTH  request data
- o_valid  output  ENTRIES  per-target valid; at most one bit set
- i_ready  input  ENTRIES  per-target ready
- o_data  output  WIDTH  request data, shared by all targets
- o_error  output  1  one-cycle pulse when a request with a bad select is discarded
- o_error_count  output  COUNT_WIDTH  saturating count of discarded requests

## Operation
- Upstream transfer: a transfer occurs when i_valid && o_ready. i_valid may depend on o_ready; o_ready never depends on i_valid.
- Select validity:
  - A select is valid when exactly one bit is set.
  - For ENTRIES==1, i_select is ignored and is always treated as valid.
- Bad select (zero bits set, or more than one):
  - The request is consumed and does not occupy storage.
  - o_error goes to 1 on the next cycle, for one cycle.
  - o_error_count increments and saturates at all-ones.
- Storage: two slots, main and skid. Each slot holds data, select and a valid flag.
- Outputs:
  - o_valid[k] = main_valid & main_select[k].
  - o_data = main data; o_data holds its value while main is empty.
- Downstream transfer: a transfer occurs when o_valid[k] && i_ready[k] for the selected k. i_ready bits of non-selected targets are ignored.
- o_ready = !skid_valid (registered).
- Good-select request is accepted:
  - Into main if main is empty or main transfers downstream in the same cycle.
  - Otherwise into skid.
- Main transfers downstream while skid is full: skid moves to main and skid becomes empty.
- Order is preserved strictly; there is no reordering across targets.

## Timing
- Reset values: o_ready=1, o_valid=0, o_data=0, o_error=0, o_error_count=0. Both slots are empty during reset.
- Latency: a request accepted on cycle N appears on o_valid/o_data on cycle N+1 when main was empty or drained on cycle N.
- Throughput: one request per cycle when the selected target holds i_ready high continuously.
- Main full, no downstream transfer, upstream transfer: the request goes to skid, and o_ready=0 from the next cycle.
- Skid full and main drains: o_ready=1 on the next cycle. Skid data is visible on o_data on the next cycle.
- Simultaneous upstream and downstream transfer with skid empty: the new request replaces main. o_valid stays high if the new select is good; the target may differ.
- Bad select accepted at the same time as a downstream transfer: main drains normally and the bad request leaves no trace except o_error and the counter.
- Reset asserted mid-operation: all held requests are dropped with no handshake, and the counter clears.

## Structure
- The shared package holds:
  - the one-hot validity function (zero or multiple bits set gives bad), reused by other rggen blocks;
  - the slot struct typedef (data, select, valid), parameterized through WIDTH/ENTRIES at use site, or packed as logic vectors if parameterized typedefs are unsupported.
- One natural sub-module: rggen_skid_buffer (generic 2-slot valid/ready register, payload width WIDTH+ENTRIES). rggen_demux wraps it with the select check, error pulse/counter and per-target valid/ready decode.

## Test plan
- Reset then single request, select=2'b10, data=32'hA5A5_0001, i_ready=2'b10 -> o_valid=2'b10 one cycle later with o_data=32'hA5A5_0001, held for one cycle only; o_ready stays 1.
- Back-to-back 8 requests alternating select 2'b01/2'b10, both targets ready -> 8 downstream transfers in 8 consecutive cycles, in order, data intact.
- Target 0 stalls (i_ready=0) with 3 requests issued -> first held in main, second in skid, o_ready=0; third waits upstream. i_ready[0]=1 -> all three are delivered in order, and o_ready returns to 1 one cycle after skid drains.
- Bad selects 2'b00 then 2'b11 -> o_error pulses twice, o_error_count=2, o_valid stays 0, o_ready stays 1.
- COUNT_WIDTH=2 with 5 bad requests -> o_error_count saturates at 3.
- Reset asserted with main and skid full -> o_valid=0, o_ready=1 and o_error_count=0 immediately; after release, no stale data is delivered.

Source files
------------

// File: rtl/rggen_demux_pkg.sv
// rtl/rggen_demux_pkg.sv - shared helpers for rggen request distribution blocks
package rggen_demux_pkg;

    // Widest select vector the one-hot check supports; callers zero-extend into it.
    localparam int MAX_SELECT_WIDTH = 64;

    // Slots are carried as packed vectors {select, data} because the slot layout
    // depends on WIDTH/ENTRIES chosen at the use site.

    // True when exactly one bit is set; zero or multiple bits is a bad select.
    function automatic logic is_onehot(input logic [MAX_SELECT_WIDTH-1:0] sel);
        logic [MAX_SELECT_WIDTH-1:0] low_cleared;
        low_cleared = sel & (sel - MAX_SELECT_WIDTH'(1));
        return (sel != '0) && (low_cleared == '0);
    endfunction

endpackage

// File: rtl/rggen_skid_buffer.sv
// rtl/rggen_skid_buffer.sv - two-slot registered valid/ready stage with skid slot
module rggen_skid_buffer #(
    parameter int WIDTH = 34
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data
);

    logic             main_valid;
    logic [WIDTH-1:0] main_data;
    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;
    logic             up_xfer;
    logic             dn_xfer;

    // Upstream ready comes straight from a flop, so downstream ready never
    // reaches it combinationally.
    assign o_ready = !skid_valid;
    assign o_valid = main_valid;
    assign o_data  = main_data;

    assign up_xfer = i_valid && !skid_valid;
    assign dn_xfer = main_valid && i_ready;

    // Slot occupancy: skid refills main on drain, otherwise new data lands in
    // main when it is free (or freeing this cycle) and in skid when it is not.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (skid_valid) begin
            if (dn_xfer) begin
                skid_valid <= 1'b0;
            end
        end else if (up_xfer) begin
            if (!main_valid || dn_xfer) begin
                main_valid <= 1'b1;
            end else begin
                skid_valid <= 1'b1;
            end
        end else if (dn_xfer) begin
            main_valid <= 1'b0;
        end
    end

    // Slot payloads only load on a fill, so o_data holds while main is empty.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            main_data <= '0;
            skid_data <= '0;
        end else if (skid_valid) begin
            if (dn_xfer) begin
                main_data <= skid_data;
            end
        end else if (up_xfer) begin
            if (!main_valid || dn_xfer) begin
                main_data <= i_data;
            end else begin
                skid_data <= i_data;
            end
        end
    end

endmodule

// File: rtl/rggen_demux.sv
// rtl/rggen_demux.sv - one-hot request demux with skid buffering and bad-select counting
module rggen_demux #(
    parameter int WIDTH       = 32,
    parameter int ENTRIES     = 2,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [ENTRIES-1:0]     i_select,
    input  logic [WIDTH-1:0]       i_data,
    output logic [ENTRIES-1:0]     o_valid,
    input  logic [ENTRIES-1:0]     i_ready,
    output logic [WIDTH-1:0]       o_data,
    output logic                   o_error,
    output logic [COUNT_WIDTH-1:0] o_error_count
);

    import rggen_demux_pkg::*;

    localparam int PAYLOAD_WIDTH = WIDTH + ENTRIES;

    logic                     select_good;
    logic [ENTRIES-1:0]       stored_select;
    logic                     buf_in_valid;
    logic                     buf_ready;
    logic                     main_valid;
    logic [PAYLOAD_WIDTH-1:0] main_payload;
    logic [ENTRIES-1:0]       main_select;
    logic                     target_ready;
    logic                     bad_xfer;
    logic                     error_q;
    logic [COUNT_WIDTH-1:0]   error_count_q;

    // A single target needs no select; treat it as always addressed.
    generate
        if (ENTRIES == 1) begin : g_single
            logic unused_select;
            assign unused_select = ^i_select;
            assign select_good   = 1'b1;
            assign stored_select = '1;
        end else begin : g_multi
            logic [MAX_SELECT_WIDTH-1:0] select_ext;
            assign select_ext    = MAX_SELECT_WIDTH'(i_select);
            assign select_good   = is_onehot(select_ext);
            assign stored_select = i_select;
        end
    endgenerate

    // Bad requests are consumed here and never enter storage.
    assign buf_in_valid = i_valid && select_good;
    assign bad_xfer     = i_valid && buf_ready && !select_good;

    assign {main_select, o_data} = main_payload;
    assign o_valid      = {ENTRIES{main_valid}} & main_select;
    assign target_ready = |(o_valid & i_ready);
    assign o_ready      = buf_ready;

    rggen_skid_buffer #(
        .WIDTH (PAYLOAD_WIDTH)
    ) u_skid_buffer (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_valid (buf_in_valid),
        .o_ready (buf_ready),
        .i_data  ({stored_select, i_data}),
        .o_valid (main_valid),
        .i_ready (target_ready),
        .o_data  (main_payload)
    );

    // One-cycle error pulse following each discarded request.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            error_q <= 1'b0;
        end else begin
            error_q <= bad_xfer;
        end
    end

    // Saturating count of discarded requests.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            error_count_q <= '0;
        end else if (bad_xfer && (error_count_q != '1)) begin
            error_count_q <= error_count_q + COUNT_WIDTH'(1);
        end
    end

    assign o_error       = error_q;
    assign o_error_count = error_count_q;

endmodule

// File: tb/tb_rggen_demux.sv
// tb/tb_rggen_demux.sv - directed self-checking bench for rggen_demux
module tb_rggen_demux;

    logic        clk;
    logic        rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [1:0]  i_select;
    logic [31:0] i_data;
    logic [1:0]  o_valid;
    logic [1:0]  i_ready;
    logic [31:0] o_data;
    logic        o_error;
    logic [7:0]  o_error_count;

    logic        s_ready;
    logic [1:0]  s_valid;
    logic [31:0] s_data;
    logic        s_error;
    logic [1:0]  s_error_count;

    int tests;
    int fails;

    rggen_demux #(.WIDTH(32), .ENTRIES(2), .COUNT_WIDTH(8)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_select      (i_select),
        .i_data        (i_data),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_data        (o_data),
        .o_error       (o_error),
        .o_error_count (o_error_count)
    );

    rggen_demux #(.WIDTH(32), .ENTRIES(2), .COUNT_WIDTH(2)) dut_sat (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_valid       (i_valid),
        .o_ready       (s_ready),
        .i_select      (i_select),
        .i_data        (i_data),
        .o_valid       (s_valid),
        .i_ready       (i_ready),
        .o_data        (s_data),
        .o_error       (s_error),
        .o_error_count (s_error_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] exp_sel;

    initial begin
        tests    = 0;
        fails    = 0;
        rst_n    = 1'b0;
        i_valid  = 1'b0;
        i_select = 2'b00;
        i_data   = 32'h0;
        i_ready  = 2'b00;
        step();
        step();
        check("rst_ready", 64'(o_ready), 64'd1);
        check("rst_valid", 64'(o_valid), 64'd0);
        check("rst_data", 64'(o_data), 64'd0);
        check("rst_error", 64'(o_error), 64'd0);
        check("rst_count", 64'(o_error_count), 64'd0);
        rst_n = 1'b1;
        step();

        // single request to target 1
        i_valid  = 1'b1;
        i_select = 2'b10;
        i_data   = 32'hA5A5_0001;
        i_ready  = 2'b10;
        step();
        i_valid = 1'b0;
        check("single_valid", 64'(o_valid), 64'h2);
        check("single_data", 64'(o_data), 64'hA5A5_0001);
        check("single_ready", 64'(o_ready), 64'd1);
        step();
        check("single_drained", 64'(o_valid), 64'd0);
        check("single_hold_data", 64'(o_data), 64'hA5A5_0001);
        check("single_ready2", 64'(o_ready), 64'd1);

        // back-to-back alternating targets, both ready
        i_ready = 2'b11;
        for (int i = 0; i < 8; i++) begin
            i_valid  = 1'b1;
            i_select = (i % 2 == 0) ? 2'b01 : 2'b10;
            i_data   = 32'h0000_0100 + 32'(i);
            exp_sel  = i_select;
            step();
            check("b2b_valid", 64'(o_valid), 64'(exp_sel));
            check("b2b_data", 64'(o_data), 64'h100 + 64'(i));
            check("b2b_ready", 64'(o_ready), 64'd1);
        end
        i_valid = 1'b0;
        step();
        check("b2b_empty", 64'(o_valid), 64'd0);

        // target 0 stalls with three requests
        i_ready  = 2'b00;
        i_valid  = 1'b1;
        i_select = 2'b01;
        i_data   = 32'hC000_000A;
        step();
        check("stall_a_ready", 64'(o_ready), 64'd1);
        i_data = 32'hC000_000B;
        step();
        i_data = 32'hC000_000C;
        check("stall_skid_ready", 64'(o_ready), 64'd0);
        check("stall_main_data", 64'(o_data), 64'hC000_000A);
        check("stall_main_valid", 64'(o_valid), 64'h1);
        step();
        check("stall_hold_ready", 64'(o_ready), 64'd0);
        check("stall_hold_data", 64'(o_data), 64'hC000_000A);
        i_ready = 2'b01;
        step();
        check("stall_b_data", 64'(o_data), 64'hC000_000B);
        check("stall_b_ready", 64'(o_ready), 64'd1);
        step();
        i_valid = 1'b0;
        check("stall_c_data", 64'(o_data), 64'hC000_000C);
        check("stall_c_valid", 64'(o_valid), 64'h1);
        step();
        check("stall_done", 64'(o_valid), 64'd0);

        // bad selects
        i_ready  = 2'b11;
        i_valid  = 1'b1;
        i_select = 2'b00;
        i_data   = 32'hDEAD_0000;
        step();
        check("bad0_error", 64'(o_error), 64'd1);
        check("bad0_count", 64'(o_error_count), 64'd1);
        check("bad0_valid", 64'(o_valid), 64'd0);
        i_select = 2'b11;
        step();
        i_valid = 1'b0;
        check("bad3_error", 64'(o_error), 64'd1);
        check("bad3_count", 64'(o_error_count), 64'd2);
        check("bad3_valid", 64'(o_valid), 64'd0);
        check("bad3_ready", 64'(o_ready), 64'd1);
        step();
        check("bad_pulse_end", 64'(o_error), 64'd0);
        check("bad_count_hold", 64'(o_error_count), 64'd2);
        check("sat_count2", 64'(s_error_count), 64'd2);

        // three more bad requests: 8-bit counter reaches 5, 2-bit saturates at 3
        i_valid  = 1'b1;
        i_select = 2'b11;
        for (int i = 0; i < 3; i++) step();
        i_valid = 1'b0;
        step();
        check("count5", 64'(o_error_count), 64'd5);
        check("sat_count3", 64'(s_error_count), 64'd3);

        // bad select arriving while main drains
        i_ready  = 2'b00;
        i_valid  = 1'b1;
        i_select = 2'b10;
        i_data   = 32'h0000_00D1;
        step();
        i_ready  = 2'b10;
        i_select = 2'b00;
        i_data   = 32'hBAD0_BAD0;
        step();
        i_valid = 1'b0;
        check("drain_bad_valid", 64'(o_valid), 64'd0);
        check("drain_bad_error", 64'(o_error), 64'd1);
        check("drain_bad_count", 64'(o_error_count), 64'd6);
        check("drain_bad_data", 64'(o_data), 64'h0000_00D1);

        // reset with main and skid full
        i_ready  = 2'b00;
        i_valid  = 1'b1;
        i_select = 2'b01;
        i_data   = 32'hF000_0001;
        step();
        i_data = 32'hF000_0002;
        step();
        i_valid = 1'b0;
        check("full_ready", 64'(o_ready), 64'd0);
        check("full_valid", 64'(o_valid), 64'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(o_valid), 64'd0);
        check("arst_ready", 64'(o_ready), 64'd1);
        check("arst_count", 64'(o_error_count), 64'd0);
        check("arst_sat_count", 64'(s_error_count), 64'd0);
        step();
        rst_n   = 1'b1;
        i_ready = 2'b11;
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_rst_valid", 64'(o_valid), 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
